// File: rtl/cbc_block_sequencer.sv
// CBC-mode sequencer for a single-block cipher core with an ap_ctrl_hs
// handshake. It owns the chaining register, the block counter and the
// streaming in/out handshakes. The core only applies the per-block
// transform.
module cbc_block_sequencer #(
  parameter int BLOCK_W = 32,
  parameter int KEY_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  input  logic               encrypt_decrypt,
  input  logic [CNT_W-1:0]   num_blocks,
  input  logic [BLOCK_W-1:0] iv,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               core_ap_start,
  input  logic               core_ap_ready,
  input  logic               core_ap_done,
  output logic [BLOCK_W-1:0] core_din,
  output logic [KEY_W-1:0]   core_key,
  input  logic [BLOCK_W-1:0] core_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CORE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state;
  logic               mode_enc;
  logic [CNT_W-1:0]   nblk;
  logic [CNT_W-1:0]   cnt;
  logic [BLOCK_W-1:0] chain;
  logic [BLOCK_W-1:0] blk;
  logic [KEY_W-1:0]   key_q;

  assign core_key = key_q;

  // Job controller: every handshake output is registered and is set on the
  // transition into the state that owns it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= S_IDLE;
      ap_done       <= 1'b0;
      ap_ready      <= 1'b0;
      ap_idle       <= 1'b1;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      core_ap_start <= 1'b0;
      out_data      <= '0;
      core_din      <= '0;
      chain         <= '0;
      cnt           <= '0;
      blk           <= '0;
      nblk          <= '0;
      key_q         <= '0;
      mode_enc      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            mode_enc <= encrypt_decrypt;
            nblk     <= num_blocks;
            key_q    <= key;
            chain    <= iv;
            cnt      <= '0;
            ap_idle  <= 1'b0;
            if (num_blocks == '0) begin
              state    <= S_DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              state    <= S_FETCH;
              in_ready <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (in_valid) begin
            blk           <= in_data;
            core_din      <= mode_enc ? (in_data ^ chain) : in_data;
            in_ready      <= 1'b0;
            core_ap_start <= 1'b1;
            state         <= S_CORE;
          end
        end

        S_CORE: begin
          // Start drops once the core has taken its inputs; the result may
          // arrive in the same cycle (combinational core) or any time later.
          if (core_ap_start && core_ap_ready) begin
            core_ap_start <= 1'b0;
          end
          if (core_ap_done) begin
            core_ap_start <= 1'b0;
            if (mode_enc) begin
              out_data <= core_dout;
              chain    <= core_dout;
            end else begin
              out_data <= core_dout ^ chain;
              chain    <= blk;
            end
            out_valid <= 1'b1;
            out_last  <= (cnt == nblk - CNT_W'(1));
            state     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            if (out_last) begin
              state    <= S_DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              state    <= S_FETCH;
              in_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
